dmem_responder: RTL

- Multi-cycle data-memory responder: the memory-side end of the data-memory request interface driven by the pipelined CPU's MEM stage.
- Accepts one word read/write request through a valid/ready handshake, models a fixed access latency, then returns a one-cycle response with read data and an error flag.
- Owns its own word storage array.
- The CPU stalls on req_ready/busy until resp_valid arrives.

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory-side end of the CPU data-memory request interface. It accepts one
//   word load/store through a valid/ready handshake, waits a fixed access
//   latency, then pulses a one-cycle response with read data and an error
//   flag. The word storage array lives inside this block.
//
// Parameters
//   DEPTH    number of 32-bit words (word index = req_addr[31:2])
//   LATENCY  rising edges from acceptance to response, legal range 1..15
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req_valid         request present, held stable by the initiator until taken
//   req_write         1 = store word, 0 = load word
//   req_addr          byte address
//   req_wdata         store data
//   req_ready         responder accepts a request this cycle (state IDLE)
//   resp_valid        one-cycle response strobe
//   resp_rdata        load data, meaningful only with resp_valid
//   resp_err          misaligned or out-of-range access, valid with resp_valid
//   busy              a request is in flight (state != IDLE)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;

  logic [31:0] mem_q [DEPTH];

  // Access performed on the edge that enters RESP. With LATENCY = 1 that edge
  // is the accepting edge itself, so the live request fields are used instead
  // of the latched copy.
  logic          commit;
  logic          c_wr;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic          c_bad;
  logic [AW-1:0] c_idx;
  logic          mem_we;

  assign c_bad = (c_addr[1:0] != 2'b00) ||
                 ({2'b00, c_addr[31:2]} >= 32'(DEPTH));
  assign c_idx = c_addr[AW+1:2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    commit       = 1'b0;
    c_wr         = wr_q;
    c_addr       = addr_q;
    c_wdata      = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            commit  = 1'b1;
            c_wr    = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (commit) begin
      if (c_bad) begin
        resp_err_d   = 1'b1;
        resp_rdata_d = '0;
      end else if (c_wr) begin
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end else begin
        resp_err_d   = 1'b0;
        resp_rdata_d = mem_q[c_idx];
      end
    end

    resp_valid_d = commit;
    mem_we       = commit && c_wr && !c_bad;
    req_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Aborts any in-flight request; a latched store is dropped uncommitted.
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      if (mem_we) begin
        mem_q[c_idx] <= c_wdata;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule
